// File: rtl/sequenciador_instrucoes_if.sv
// Handshake bundle between the instruction sequencer and the host/processor side:
// program loading, start control, DIN/Run/Done and status flags.
interface sequenciador_instrucoes_if #(
    parameter int ADDR_W = 4
);
    logic              Load;
    logic [ADDR_W-1:0] LoadAddr;
    logic [15:0]       LoadData;
    logic [ADDR_W:0]   ProgLen;
    logic              Start;
    logic              Done;
    logic [15:0]       DIN;
    logic              Run;
    logic              Busy;
    logic              Finished;
    logic              Erro;
    logic [7:0]        InstrCount;

    modport master (
        output Load, LoadAddr, LoadData, ProgLen, Start, Done,
        input  DIN, Run, Busy, Finished, Erro, InstrCount
    );

    modport slave (
        input  Load, LoadAddr, LoadData, ProgLen, Start, Done,
        output DIN, Run, Busy, Finished, Erro, InstrCount
    );
endinterface

// File: rtl/sequenciador_instrucoes.sv
// Instruction sequencer: plays a loaded program buffer into the multicycle processor,
// one word per Run pulse, following mvi with its immediate and waiting for Done.
module sequenciador_instrucoes #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    sequenciador_instrucoes_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_IMM   = 2'd3;

    logic [15:0]       prog_mem [PROG_DEPTH];
    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [15:0]       hold_q, hold_d;
    logic              finished_q, finished_d;
    logic              erro_q, erro_d;
    logic [7:0]        icount_q, icount_d;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [15:0]       cur_word;
    logic [15:0]       next_word;
    logic              is_mvi;

    // The buffer wraps modulo PROG_DEPTH, so an mvi in the last word fetches word 0.
    assign cur_addr  = pc_q[ADDR_W-1:0];
    assign next_addr = cur_addr + ADDR_W'(1);
    assign cur_word  = prog_mem[cur_addr];
    assign next_word = prog_mem[next_addr];
    assign is_mvi    = (cur_word[8:6] == 3'b001);

    always_ff @(posedge Clock) begin
        if (Resetn && bus.Load && (state_q == ST_IDLE)) begin
            prog_mem[bus.LoadAddr] <= bus.LoadData;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        hold_d     = hold_q;
        finished_d = 1'b0;
        erro_d     = erro_q;
        icount_d   = icount_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    erro_d   = 1'b0;
                    icount_d = 8'd0;
                    if (bus.ProgLen == '0) begin
                        finished_d = 1'b1;
                    end else begin
                        len_d   = bus.ProgLen;
                        pc_d    = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // The immediate is captured now and PC skips past it in one step.
                wcnt_d = '0;
                if (is_mvi) begin
                    pc_d    = pc_q + (ADDR_W+1)'(2);
                    hold_d  = next_word;
                    state_d = ST_IMM;
                end else begin
                    pc_d    = pc_q + (ADDR_W+1)'(1);
                    hold_d  = cur_word;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT, ST_IMM: begin
                if (bus.Done) begin
                    if (icount_q != 8'hFF) begin
                        icount_d = icount_q + 8'd1;
                    end
                    if (pc_q >= len_q) begin
                        finished_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if (wcnt_q == CNT_W'(TIMEOUT)) begin
                    erro_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            wcnt_q     <= '0;
            hold_q     <= '0;
            finished_q <= 1'b0;
            erro_q     <= 1'b0;
            icount_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            hold_q     <= hold_d;
            finished_q <= finished_d;
            erro_q     <= erro_d;
            icount_q   <= icount_d;
        end
    end

    assign bus.Run        = (state_q == ST_ISSUE);
    assign bus.Busy       = (state_q != ST_IDLE);
    assign bus.DIN        = (state_q == ST_ISSUE) ? cur_word :
                            (state_q == ST_IDLE)  ? 16'h0000 : hold_q;
    assign bus.Finished   = finished_q;
    assign bus.Erro       = erro_q;
    assign bus.InstrCount = icount_q;
endmodule
